regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the register file's single write port (write_reg/write_data/write_enable) among
//   NUM_REQ writeback requesters (ALU, load unit, mult/div, etc.) using round-robin arbitration.
//   Each requester uses a valid/ready handshake. The winner is latched into an output stage
//   that drives register_file directly. Sits between the execution units and register_file.
// PARAMETERS
//   NUM_REQ  4   number of writeback requesters (2..8)
//   DATA_W   32  write data width; must equal register_file data width
//   ADDR_W   5   register index width (32 registers)
// PORTS
//   clk           in   1               rising-edge clock, shared with register_file
//   areset        in   1               asynchronous reset, active-high
//   hold          in   1               1 = grant nothing this cycle (core stall)
//   req_valid     in   NUM_REQ         per-requester write request
//   req_reg       in   NUM_REQ*ADDR_W  destination index; requester i at [i*ADDR_W +: ADDR_W]
//   req_data      in   NUM_REQ*DATA_W  write data; requester i at [i*DATA_W +: DATA_W]
//   req_ready     out  NUM_REQ         one-hot grant; handshake completes when valid & ready
//   write_reg     out  ADDR_W          to register_file write_reg
//   write_data    out  DATA_W          to register_file write_data
//   write_enable  out  1               to register_file write_enable
//   grant_id      out  $clog2(NUM_REQ) index of the requester driving the output stage
//   pending_mask  out  32              one-hot of write_reg while write_enable=1, else 0
// BEHAVIOUR
//   - Reset (async, areset=1): rr_ptr=0; write_enable=0; write_reg=0; write_data=0;
//     grant_id=0; pending_mask=0. A write held in the output stage is dropped, never committed.
//   - req_ready is combinational from req_valid, rr_ptr and hold, and has no dependence on data.
//     At most one bit is set. It is all-zero when hold=1 or req_valid=0.
//   - Arbitration: scan from index rr_ptr upward, wrapping at NUM_REQ-1 -> 0. The first
//     valid index wins. On a grant to index g, rr_ptr <= (g+1) mod NUM_REQ. With no grant,
//     rr_ptr is unchanged.
//   - Latency: a request granted in cycle N appears on write_* during cycle N+1. register_file
//     commits it on the rising edge that ends cycle N+1. This gives one write per cycle, sustained.
//   - The output stage reloads every cycle. With no grant, write_enable <= 0, and write_reg,
//     write_data and grant_id hold their previous values.
//   - req_reg == 0: the handshake completes and rr_ptr advances, but write_enable <= 0.
//     This keeps $zero unwritten and pending_mask at 0.
//   - A requester keeps req_reg and req_data stable while req_valid=1 && req_ready=0.
//     Dropping req_valid before a grant is allowed, and that request is then lost.
//   - If two requesters target the same register, they are serviced in grant order, one per
//     cycle. The later grant overwrites. No merging takes place.
//   - hold=1 does not stop the output stage. A write already latched still commits, and the
//     following cycle then shows write_enable=0.
//   - pending_mask lets decode detect a read of a register whose write commits this cycle,
//     so it can forward or stall.
// STRUCTURE
//   - Shared package gac_pkg: REG_ADDR_W=5, REG_DATA_W=32, REG_COUNT=32, REG_ZERO=5'd0.
//   - Sub-module gac_rr_arbiter #(N): inputs req, ptr, en; outputs one-hot gnt, gnt_idx, any.
//     It is purely combinational and reusable for a future memory-port arbiter.
//   - Top level: arbiter instance, data/addr mux selected by gnt_idx, output-stage registers,
//     rr_ptr register, and pending_mask decode from write_reg (gac_dec_5 may be reused).
// TESTING
//   1. Reset: assert areset mid-cycle while write_enable=1. Outputs go to 0 immediately,
//      rr_ptr=0, and the register file's r5 is unchanged.
//   2. Single request: req_valid=4'b0001, req_reg0=5'd8, data0=32'hDEADBEEF.
//      Same cycle: req_ready=0001. Next cycle: write_enable=1, write_reg=8, pending_mask=32'h100.
//   3. Round-robin: all 4 valid for 8 cycles with regs 1..4. Grants are 0,1,2,3,0,1,2,3,
//      write_enable=1 in every cycle after the first, and the stored values match.
//   4. Zero register: req_reg1=0, data=32'h1234. req_ready1=1 and rr_ptr goes to 2, but
//      write_enable=0 and pending_mask=0. Reading r0 returns 0.
//   5. Hold: all valid with hold=1 for 3 cycles. req_ready=0, rr_ptr is frozen, and
//      write_enable=0 after the first cycle. Releasing hold grants the frozen rr_ptr index first.
//   6. Same-destination collision: req0 and req2 both target reg 9 with 32'hA and 32'hB,
//      rr_ptr=0. Two writes occur in order, and r9 ends at 32'hB.

Source files
------------

// File: rtl/gac_pkg.sv
// Shared register-file constants and a one-hot index decoder, shared by the
// writeback arbiter and future register-file port logic.
package gac_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int REG_COUNT  = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  function automatic logic [REG_COUNT-1:0] dec_onehot(input logic [REG_ADDR_W-1:0] addr);
    logic [REG_COUNT-1:0] v;
    v       = '0;
    v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/gac_rr_arbiter.sv
// Combinational round-robin arbiter: scans from ptr upward with wrap-around
// and returns the first set request as a one-hot grant plus its index.
module gac_rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int            w_idx;
  logic [IW-1:0] w_cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_idx   = 0;
    w_cand  = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      w_cand = IW'(w_idx);
      if (en && !any && req[w_cand]) begin
        any          = 1'b1;
        gnt[w_cand]  = 1'b1;
        gnt_idx      = w_cand;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among
// NUM_REQ writeback units, with a one-cycle registered output stage.
module regfile_wb_arbiter
  import gac_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = REG_DATA_W,
  parameter  int ADDR_W  = REG_ADDR_W,
  localparam int IW      = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      areset,
  input  logic                      hold,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic                      write_enable,
  output logic [IW-1:0]             grant_id,
  output logic [REG_COUNT-1:0]      pending_mask
);

  logic [IW-1:0]     r_rr_ptr;
  logic              r_write_en;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic [IW-1:0]     r_grant_id;

  logic [NUM_REQ-1:0] w_gnt;
  logic [IW-1:0]      w_gnt_idx;
  logic               w_any;
  logic [IW-1:0]      w_next_ptr;
  logic [ADDR_W-1:0]  w_sel_reg;
  logic [DATA_W-1:0]  w_sel_data;
  logic [ADDR_W-1:0]  w_reg_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_data_arr [NUM_REQ];

  gac_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .en      (~hold),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign w_reg_arr[i]  = req_reg[i*ADDR_W +: ADDR_W];
    assign w_data_arr[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign w_sel_reg  = w_reg_arr[w_gnt_idx];
  assign w_sel_data = w_data_arr[w_gnt_idx];
  assign w_next_ptr = (w_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      r_rr_ptr     <= '0;
      r_write_en   <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_grant_id   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_write_en <= 1'b0;
      if (w_any) begin
        r_rr_ptr     <= w_next_ptr;
        // A grant to $zero completes the handshake but never reaches the register file.
        r_write_en   <= (w_sel_reg != ADDR_W'(REG_ZERO));
        r_write_reg  <= w_sel_reg;
        r_write_data <= w_sel_data;
        r_grant_id   <= w_gnt_idx;
      end
    end
  end

  assign req_ready    = w_gnt;
  assign write_reg    = r_write_reg;
  assign write_data   = r_write_data;
  assign write_enable = r_write_en;
  assign grant_id     = r_grant_id;
  assign pending_mask = r_write_en ? dec_onehot(REG_ADDR_W'(r_write_reg)) : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: an independent round-robin model feeds a
// scoreboard of expected write-port values, plus a behavioural register file.
module tb_regfile_wb_arbiter;

  localparam int N  = 4;
  localparam int AW = 5;
  localparam int DW = 32;

  typedef struct {
    logic          we;
    logic [AW-1:0] wreg;
    logic [DW-1:0] wdata;
    logic [1:0]    gid;
    bit            cmp_bus;
  } exp_t;

  logic            clk = 1'b0;
  logic            areset;
  logic            hold;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [AW-1:0]   write_reg;
  logic [DW-1:0]   write_data;
  logic            write_enable;
  logic [1:0]      grant_id;
  logic [31:0]     pending_mask;

  logic [DW-1:0] rf [32] = '{default: '0};

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int            m_ptr;
  logic [AW-1:0] m_reg;
  logic [DW-1:0] m_data;
  logic [1:0]    m_gid;
  bit            m_known;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .areset       (areset),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_reg      (req_reg),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_enable (write_enable),
    .grant_id     (grant_id),
    .pending_mask (pending_mask)
  );

  // Behavioural register file: commits any enabled write, r0 included.
  always @(posedge clk) begin
    if (write_enable) rf[write_reg] <= write_data;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] r, input logic [DW-1:0] d);
    req_reg[i*AW +: AW]  = r;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_reg   = '0;
    m_data  = '0;
    m_gid   = '0;
    m_known = 1'b1;
    sb.delete();
  endtask

  // Inputs are applied at a negedge; one full clock is run and the write port checked.
  task automatic step();
    int   g;
    exp_t e;
    logic [N-1:0] exp_rdy;
    #1;
    g = -1;
    if (!hold) begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && req_valid[i]) g = i;
      end
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    e.we = 1'b0;
    if (g >= 0) begin
      m_reg   = req_reg[g*AW +: AW];
      m_data  = req_data[g*DW +: DW];
      m_gid   = 2'(g);
      e.we    = (m_reg != 0);
      m_known = e.we;
      m_ptr   = (g + 1) % N;
    end
    e.wreg    = m_reg;
    e.wdata   = m_data;
    e.gid     = m_gid;
    e.cmp_bus = m_known;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    check("write_enable", write_enable, e.we);
    check("pending_mask", pending_mask, e.we ? (32'h1 << e.wreg) : 32'h0);
    check("rr_ptr", dut.r_rr_ptr, m_ptr);
    if (e.cmp_bus) begin
      check("write_reg", write_reg, e.wreg);
      check("write_data", write_data, e.wdata);
      check("grant_id", grant_id, e.gid);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    areset    = 1'b1;
    req_valid = '0;
    hold      = 1'b0;
    #1;
    check("rst_we", write_enable, 1'b0);
    check("rst_reg", write_reg, '0);
    check("rst_data", write_data, '0);
    check("rst_gid", grant_id, '0);
    check("rst_pending", pending_mask, '0);
    check("rst_ptr", dut.r_rr_ptr, '0);
    @(negedge clk);
    areset = 1'b0;
    model_reset();
  endtask

  task automatic idle();
    req_valid = '0;
    step();
  endtask

  initial begin
    areset    = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Reset mid-cycle drops a latched write to r5.
    set_req(0, 5'd5, 32'h55);
    req_valid = 4'b0001;
    step();
    idle();
    check("r5_init", rf[5], 32'h55);
    set_req(0, 5'd5, 32'h66);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    #2 areset = 1'b1;
    #1;
    check("midrst_we", write_enable, 1'b0);
    check("midrst_reg", write_reg, '0);
    check("midrst_data", write_data, '0);
    check("midrst_pending", pending_mask, '0);
    check("midrst_ptr", dut.r_rr_ptr, '0);
    @(posedge clk);
    @(negedge clk);
    check("r5_kept", rf[5], 32'h55);
    areset = 1'b0;
    model_reset();

    // Single request.
    set_req(0, 5'd8, 32'hDEADBEEF);
    req_valid = 4'b0001;
    step();
    check("single_pending", pending_mask, 32'h100);
    idle();
    check("r8", rf[8], 32'hDEADBEEF);

    // Round-robin across all four requesters.
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 5'(i + 1), 32'hC000_0000 + 32'(i));
    req_valid = 4'b1111;
    repeat (8) step();
    idle();
    for (int i = 0; i < N; i++) check("rr_store", rf[i+1], 32'hC000_0000 + 32'(i));

    // Writes to $zero are swallowed.
    do_reset();
    set_req(0, 5'd3, 32'h33);
    req_valid = 4'b0001;
    step();
    set_req(1, 5'd0, 32'h1234);
    req_valid = 4'b0010;
    step();
    idle();
    check("r0_zero", rf[0], 32'h0);
    check("r3", rf[3], 32'h33);

    // Hold freezes arbitration but lets the latched write commit.
    do_reset();
    set_req(0, 5'd7, 32'h77);
    req_valid = 4'b0001;
    step();
    for (int i = 0; i < N; i++) set_req(i, 5'(10 + i), 32'hB0 + 32'(i));
    req_valid = 4'b1111;
    hold      = 1'b1;
    repeat (3) step();
    check("hold_commit", rf[7], 32'h77);
    hold = 1'b0;
    #1;
    check("hold_release", req_ready, 4'b0010);
    step();
    idle();
    check("r11", rf[11], 32'hB1);

    // Same-destination collision, serviced in grant order.
    do_reset();
    set_req(0, 5'd9, 32'hA);
    set_req(2, 5'd9, 32'hB);
    req_valid = 4'b0101;
    step();
    req_valid = 4'b0100;
    step();
    check("r9_first", rf[9], 32'hA);
    idle();
    check("r9_last", rf[9], 32'hB);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
